// File: rtl/fp_pkg.sv
// Shared single-precision constants, FSM encoding and small result builders
// used by the divider and its operand classifier.
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;
  localparam int DIV_ITER = 26;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_ROUND,
    S_DONE
  } state_e;

  function automatic logic [31:0] fp_inf(input logic sign);
    return {sign, {FP_EXP_W{1'b1}}, {FP_MAN_W{1'b0}}};
  endfunction

  function automatic logic [31:0] fp_zero(input logic sign);
    return {sign, 31'h0};
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational zero/inf/NaN flags for one operand; denormals report as zero.
module fp_classify
  import fp_pkg::*;
(
  input  logic [30:0] mag,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);

  logic [FP_EXP_W-1:0] exp_f;
  logic [FP_MAN_W-1:0] man_f;

  assign exp_f   = mag[30:FP_MAN_W];
  assign man_f   = mag[FP_MAN_W-1:0];
  assign is_zero = (exp_f == '0);
  assign is_inf  = (exp_f == '1) && (man_f == '0);
  assign is_nan  = (exp_f == '1) && (man_f != '0);

endmodule

// File: rtl/float_divider.sv
// Fixed-latency IEEE-754 single-precision divider: 26-cycle restoring division,
// one normalise/round cycle, one delivery cycle; done pulses 28 edges after start.
module float_divider
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  output logic [31:0] output_z,
  output logic        busy,
  output logic        done,
  output logic        exception
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [25:0] rem_q, rem_d, quo_q, quo_d;
  logic [31:0] res_q, res_d, z_q, z_d;
  logic        res_exc_q, res_exc_d, exc_q, exc_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic zero_a, inf_a, nan_a, zero_b, inf_b, nan_b;

  fp_classify u_class_a (.mag(a_q[30:0]), .is_zero(zero_a), .is_inf(inf_a), .is_nan(nan_a));
  fp_classify u_class_b (.mag(b_q[30:0]), .is_zero(zero_b), .is_inf(inf_b), .is_nan(nan_b));

  logic [25:0] mb_ext;
  logic        rem_ge;

  assign mb_ext = {2'b00, 1'b1, b_q[FP_MAN_W-1:0]};
  assign rem_ge = (rem_q >= mb_ext);

  logic               sign;
  logic signed [9:0]  exp_s, exp_n, exp_f;
  logic [22:0]        mant;
  logic [23:0]        mant_r;
  logic               guard, sticky, round_up;
  logic [31:0]        calc_z;
  logic               calc_exc;

  // Normalise, round-to-nearest-even, range check, then special-case override.
  always_comb begin
    sign  = a_q[31] ^ b_q[31];
    exp_s = 10'({2'b00, a_q[30:23]}) - 10'({2'b00, b_q[30:23]}) + 10'(FP_BIAS);
    if (quo_q[25]) begin
      mant   = quo_q[24:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (|rem_q);
      exp_n  = exp_s;
    end else begin
      mant   = quo_q[23:1];
      guard  = quo_q[0];
      sticky = |rem_q;
      exp_n  = exp_s - 10'sd1;
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {23'b0, round_up};
    exp_f    = exp_n + $signed({9'b0, mant_r[23]});

    calc_exc = 1'b0;
    if (exp_f >= 10'sd255)     calc_z = fp_inf(sign);
    else if (exp_f <= 10'sd0)  calc_z = fp_zero(sign);
    else                       calc_z = {sign, exp_f[7:0], mant_r[22:0]};

    if (nan_a || nan_b) begin
      calc_z = QNAN;
    end else if ((zero_a && zero_b) || (inf_a && inf_b)) begin
      calc_z   = QNAN;
      calc_exc = 1'b1;
    end else if (zero_b && !inf_a) begin
      calc_z   = fp_inf(sign);
      calc_exc = 1'b1;
    end else if (inf_a) begin
      calc_z = fp_inf(sign);
    end else if (inf_b || zero_a) begin
      calc_z = fp_zero(sign);
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    res_d     = res_q;
    res_exc_d = res_exc_q;
    z_d       = z_q;
    exc_d     = exc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = input_a;
          b_d     = input_b;
          rem_d   = {2'b00, 1'b1, input_a[FP_MAN_W-1:0]};
          quo_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        quo_d = {quo_q[24:0], rem_ge};
        rem_d = (rem_ge ? (rem_q - mb_ext) : rem_q) << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_ITER - 1)) begin
          cnt_d   = '0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        res_d     = calc_z;
        res_exc_d = calc_exc;
        state_d   = S_DONE;
      end
      S_DONE: begin
        z_d     = res_q;
        exc_d   = res_exc_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together;
  // datapath registers are reset too, keeping outputs defined after an abort.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      res_q     <= '0;
      res_exc_q <= 1'b0;
      z_q       <= '0;
      exc_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      res_q     <= res_d;
      res_exc_q <= res_exc_d;
      z_q       <= z_d;
      exc_q     <= exc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign output_z  = z_q;
  assign exception = exc_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_float_divider.sv
// Scoreboard bench for float_divider: expected quotients are queued when an
// operation is launched and compared when done pulses.
module tb_float_divider;

  logic        clk;
  logic        clrn;
  logic        start;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic [31:0] output_z;
  logic        busy;
  logic        done;
  logic        exception;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] z;
    logic        exc;
    string       name;
  } exp_t;

  exp_t sb[$];

  float_divider dut (
    .clk      (clk),
    .clrn     (clrn),
    .start    (start),
    .input_a  (input_a),
    .input_b  (input_b),
    .output_z (output_z),
    .busy     (busy),
    .done     (done),
    .exception(exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one division, optionally re-pulse start with other operands at
  // edge poke_edge, then check latency, busy, result and hold behaviour.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] z, input logic exc,
                        input string name, input int poke_edge);
    exp_t item;
    int   lat;
    logic busy_ok;
    sb.push_back('{z: z, exc: exc, name: name});
    @(negedge clk);
    input_a = a;
    input_b = b;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    input_a = 32'hDEADBEEF;
    input_b = 32'h0BADF00D;
    lat     = 0;
    busy_ok = busy;
    for (int e = 1; e <= 40; e++) begin
      if (e == poke_edge) begin
        @(negedge clk);
        input_a = 32'h3F800000;
        input_b = 32'h40400000;
        start   = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done === 1'b1) begin
        lat = e;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    item = sb.pop_front();
    checks++;
    if (lat !== 28) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, expected 28 (0 = no done)", name, lat);
    end
    checks++;
    if (busy_ok !== 1'b1) begin
      errors++;
      $display("FAIL %s busy: dropped before done, expected high edges 0..27", name);
    end
    checks++;
    if (output_z !== item.z) begin
      errors++;
      $display("FAIL %s output_z: got %h expected %h", name, output_z, item.z);
    end
    checks++;
    if (exception !== item.exc) begin
      errors++;
      $display("FAIL %s exception: got %b expected %b", name, exception, item.exc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || output_z !== item.z || exception !== item.exc) begin
      errors++;
      $display("FAIL %s hold: done=%b z=%h exc=%b expected done=0 z=%h exc=%b",
               name, done, output_z, exception, item.z, item.exc);
    end
  endtask

  task automatic test_reset();
    clrn    = 1'b0;
    start   = 1'b0;
    input_a = '0;
    input_b = '0;
    #1;
    checks++;
    if (output_z !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || exception !== 1'b0) begin
      errors++;
      $display("FAIL reset: z=%h busy=%b done=%b exc=%b expected all 0",
               output_z, busy, done, exception);
    end
    repeat (2) @(posedge clk);
    #2;
    clrn = 1'b1;
  endtask

  task automatic test_basic();
    do_div(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, "6_div_2", 0);
    do_div(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, "1_div_3", 0);
    do_div(32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, "neg6_div_2", 0);
    do_div(32'h3F800000, 32'h40000000, 32'h3F000000, 1'b0, "1_div_2", 0);
    do_div(32'h41200000, 32'h40800000, 32'h40200000, 1'b0, "10_div_4", 0);
    do_div(32'h40000000, 32'h40400000, 32'h3F2AAAAB, 1'b0, "2_div_3", 0);
  endtask

  task automatic test_special();
    do_div(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, "1_div_0", 0);
    do_div(32'h00000000, 32'h80000000, 32'h7FC00000, 1'b1, "0_div_neg0", 0);
    do_div(32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, "neg1_div_0", 0);
    do_div(32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, "nan_div_1", 0);
    do_div(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b1, "inf_div_inf", 0);
    do_div(32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, "inf_div_2", 0);
    do_div(32'h40000000, 32'hFF800000, 32'h80000000, 1'b0, "2_div_neginf", 0);
    do_div(32'h00000000, 32'h40A00000, 32'h00000000, 1'b0, "0_div_5", 0);
    do_div(32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, "denorm_div_1", 0);
  endtask

  task automatic test_boundary();
    do_div(32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 1'b0, "overflow", 0);
    do_div(32'h00800000, 32'h7F7FFFFF, 32'h00000000, 1'b0, "underflow", 0);
  endtask

  task automatic test_busy_ignore();
    do_div(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, "start_while_busy", 10);
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    @(negedge clk);
    input_a = 32'h40C00000;
    input_b = 32'h40000000;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    clrn = 1'b0;
    #1;
    checks++;
    if (output_z !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || exception !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: z=%h busy=%b done=%b exc=%b expected all 0",
               output_z, busy, done, exception);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    @(posedge clk);
    #2;
    clrn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got done=1 for aborted op, expected none");
    end
    do_div(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, "6_div_2_after_reset", 0);
  endtask

  task automatic test_back_to_back();
    do_div(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, "b2b_1_div_1", 0);
    do_div(32'h40C00000, 32'hC0000000, 32'hC0400000, 1'b0, "b2b_6_div_neg2", 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_boundary();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
